// File: rtl/sram_spi_engine.sv
// Purpose: SPI mode-0 PHY for a 24-bit-address serial SRAM; one byte read/write per request.
// Latency: accept to resp_valid is 81 enabled cycles (40 bits x 2 phases + DONE).
// Backpressure: req_ready high only in IDLE; ena low freezes every register and pin.
//
// Ports: clk/rst_n (async active-low), ena (global clock enable),
//        req_valid/req_ready/req_write/req_addr/req_wdata (request handshake),
//        resp_valid/resp_rdata (completion pulse + read byte),
//        sram_cs/sram_sck/sram_si (pins out), sram_so (pin in).
// Optional: define SRAM_MODE_INIT_EN to issue WRMR 0x40 (sequential mode) after reset.
module sram_spi_engine (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        resp_valid,
    output logic [7:0]  resp_rdata,
    output logic        sram_cs,
    output logic        sram_sck,
    output logic        sram_si,
    input  logic        sram_so
);

`ifdef SRAM_MODE_INIT_EN
    typedef enum logic [1:0] {IDLE, SHIFT, DONE, INIT} state_t;
    localparam state_t     RST_STATE = INIT;
    // WRMR followed by the mode byte, left-aligned in the transmit register.
    localparam logic [39:0] RST_SHREG = {8'h01, 8'h40, 24'h000000};
    localparam logic       RST_INIT  = 1'b1;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam state_t     RST_STATE = IDLE;
    localparam logic [39:0] RST_SHREG = 40'h0;
    localparam logic       RST_INIT  = 1'b0;
`endif

    state_t      state, state_nxt;
    logic [39:0] shreg;
    logic [7:0]  rx_sh;
    logic [5:0]  bit_cnt;
    logic        phase;
    logic        is_read;
    logic        init_xfer;
    logic        shifting;
    logic        last_bit;

`ifdef SRAM_MODE_INIT_EN
    assign shifting = (state == SHIFT) || (state == INIT);
`else
    assign shifting = (state == SHIFT);
`endif

    // The init sequence is only 16 bits long; normal transfers are 40.
    assign last_bit = init_xfer ? (bit_cnt == 6'd15) : (bit_cnt == 6'd39);

    // Pins are decoded from registered state so a frozen ena freezes them too,
    // and an async reset of the state register raises CS without a clock.
    assign sram_cs    = ~shifting;
    assign sram_sck   = shifting & phase;
    assign sram_si    = shifting & shreg[39];
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == DONE) & ~init_xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_STATE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = SHIFT;
            SHIFT:   if (phase && last_bit) state_nxt = DONE;
`ifdef SRAM_MODE_INIT_EN
            INIT:    if (phase && last_bit) state_nxt = DONE;
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= RST_SHREG;
            rx_sh      <= 8'h00;
            bit_cnt    <= 6'd0;
            phase      <= 1'b0;
            is_read    <= 1'b0;
            init_xfer  <= RST_INIT;
            resp_rdata <= 8'h00;
        end else if (ena) begin
            if (state == IDLE) begin
                if (req_valid) begin
                    shreg     <= {req_write ? 8'h02 : 8'h03, req_addr,
                                  req_write ? req_wdata : 8'h00};
                    is_read   <= ~req_write;
                    init_xfer <= 1'b0;
                    bit_cnt   <= 6'd0;
                    phase     <= 1'b0;
                end
            end else if (shifting) begin
                if (!phase) begin
                    phase <= 1'b1;
                end else begin
                    // End of the SCK-high phase: sample SO, advance to the next bit.
                    phase   <= 1'b0;
                    shreg   <= {shreg[38:0], 1'b0};
                    rx_sh   <= {rx_sh[6:0], sram_so};
                    bit_cnt <= bit_cnt + 6'd1;
                    // The last eight samples are the data byte; publish it as DONE starts.
                    if (last_bit && is_read) begin
                        resp_rdata <= {rx_sh[6:0], sram_so};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_spi_engine.sv
// Purpose: directed self-checking bench for sram_spi_engine (default build).
// Latency: checks the 81-cycle accept-to-response timing and the 2-cycle CS gap.
// Backpressure: exercises ena freeze and async reset abort mid-transfer.
module tb_sram_spi_engine;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [23:0] req_addr;
    logic [7:0]  req_wdata;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic        sram_cs;
    logic        sram_sck;
    logic        sram_si;
    logic        sram_so;

    int checks = 0;
    int errors = 0;

    // Results of the most recent run_xfer call.
    logic [39:0] si_cap;
    int          rv_n [2];
    int          rv_cnt;
    logic [7:0]  rd_at_rv;
    int          cs_low_cnt;
    int          cs_relow_n;
    int          viol_sck;
    int          viol_si;
    int          viol_frz;

    sram_spi_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .sram_cs    (sram_cs),
        .sram_sck   (sram_sck),
        .sram_si    (sram_si),
        .sram_so    (sram_so)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues a request (held for n_xfers==2), then samples every cycle at the
    // falling edge. Cycle n is the period after the n-th edge following accept.
    // ena is dropped for edges fr_start .. fr_start+fr_len-1.
    task automatic run_xfer(input logic wr, input logic [23:0] addr, input logic [7:0] wd,
                            input logic [7:0] so_b, input int n_xfers,
                            input int fr_start, input int fr_len, input int max_n);
        logic prev_sck, prev_si, prev_cs;
        int   nbit;
        int   k;
        si_cap = '0; rv_n[0] = -1; rv_n[1] = -1; rv_cnt = 0; rd_at_rv = 8'hxx;
        cs_low_cnt = 0; cs_relow_n = -1; viol_sck = 0; viol_si = 0; viol_frz = 0;
        nbit = 0; prev_sck = 1'b0; prev_si = 1'b0; prev_cs = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        if (n_xfers == 1) req_valid = 1'b0;
        for (int n = 1; n <= max_n; n++) begin
            @(negedge clk);
            if (n > fr_start && n <= fr_start + fr_len) begin
                if (sram_cs !== prev_cs || sram_sck !== prev_sck || sram_si !== prev_si)
                    viol_frz++;
            end
            if (sram_cs && sram_sck) viol_sck++;
            if (!sram_cs && rv_cnt == 0) cs_low_cnt++;
            if (!sram_cs && rv_cnt == 1 && cs_relow_n < 0) begin
                cs_relow_n = n;
                req_valid = 1'b0;
            end
            if (sram_sck && !prev_sck) begin
                if (sram_si !== prev_si) viol_si++;
                if (nbit < 40) si_cap[39 - nbit] = sram_si;
                nbit++;
            end
            sram_so = 1'b0;
            if (sram_sck) begin
                k = (nbit - 1) % 40;
                if (k >= 32) sram_so = so_b[39 - k];
            end
            if (resp_valid) begin
                rv_n[rv_cnt] = n;
                rd_at_rv = resp_rdata;
                rv_cnt++;
            end
            ena = !(n >= fr_start && n < fr_start + fr_len);
            prev_sck = sram_sck; prev_si = sram_si; prev_cs = sram_cs;
            if (rv_cnt == n_xfers) break;
        end
        ena = 1'b1;
        req_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; sram_so = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_cs", sram_cs, 1'b1);
        chk("rst_sck", sram_sck, 1'b0);
        chk("rst_si", sram_si, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_rdata", resp_rdata, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", req_ready, 1'b1);

        // Write 0x5A to 0x012345.
        run_xfer(1'b1, 24'h012345, 8'h5A, 8'h00, 1, 0, 0, 100);
        chk("wr_si_bits", si_cap, 40'h02_012345_5A);
        chk("wr_rv_cycle", rv_n[0], 81);
        chk("wr_cs_low", cs_low_cnt, 80);
        chk("wr_rdata", rd_at_rv, 8'h00);
        chk("wr_sck_cs_high", viol_sck, 0);
        chk("wr_si_stable", viol_si, 0);
        @(negedge clk);
        chk("wr_c82_ready", req_ready, 1'b1);
        chk("wr_c82_rv_low", resp_valid, 1'b0);

        // Read 0x00FFFF, device returns 0xA5.
        run_xfer(1'b0, 24'h00FFFF, 8'h77, 8'hA5, 1, 0, 0, 100);
        chk("rd_si_bits", si_cap, 40'h03_00FFFF_00);
        chk("rd_rv_cycle", rv_n[0], 81);
        chk("rd_rdata", rd_at_rv, 8'hA5);
        @(negedge clk);
        chk("rd_rdata_hold", resp_rdata, 8'hA5);

        // ena low for 7 edges starting in the SCK-low half of bit 20.
        run_xfer(1'b0, 24'h123456, 8'h00, 8'h3C, 1, 41, 7, 110);
        chk("frz_si_bits", si_cap, 40'h03_123456_00);
        chk("frz_rv_cycle", rv_n[0], 88);
        chk("frz_rdata", rd_at_rv, 8'h3C);
        chk("frz_pins_held", viol_frz, 0);
        chk("frz_si_stable", viol_si, 0);

        // Back-to-back reads with req_valid held.
        run_xfer(1'b0, 24'hABCDEF, 8'h00, 8'h96, 2, 0, 0, 180);
        chk("b2b_rv1", rv_n[0], 81);
        chk("b2b_cs_relow", cs_relow_n, 83);
        chk("b2b_rv2", rv_n[1], 163);
        chk("b2b_rdata", rd_at_rv, 8'h96);
        chk("b2b_sck_cs_high", viol_sck, 0);

        // Async reset at cycle 40 of a read.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 24'h000010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_cs_low_before", sram_cs, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs_async", sram_cs, 1'b1);
        chk("abort_sck_async", sram_sck, 1'b0);
        begin
            int rv_seen = 0;
            repeat (3) begin
                @(negedge clk);
                if (resp_valid) rv_seen++;
            end
            rst_n = 1'b1;
            repeat (85) begin
                @(negedge clk);
                if (resp_valid) rv_seen++;
            end
            chk("abort_no_rv", rv_seen, 0);
        end
        chk("abort_ready", req_ready, 1'b1);

        // A fresh request completes normally after the abort.
        run_xfer(1'b0, 24'h000001, 8'h00, 8'hC3, 1, 0, 0, 100);
        chk("post_si_bits", si_cap, 40'h03_000001_00);
        chk("post_rv_cycle", rv_n[0], 81);
        chk("post_rdata", rd_at_rv, 8'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
